// File: rtl/x_in_conditioner.sv
// Two-flop synchronizer + debounce FSM producing one registered pulse per accepted edge of raw_in.
// Latency: DB_CYCLES+1 edges from first sampling edge to pulse; no backpressure (free-running input).
module x_in_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3,
    parameter int EDGE_MODE = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic x_pulse,
    output logic x_level,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1, s2;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt;

    // s1 may go metastable; only s2 feeds the debouncer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= LOW;
            cnt     <= '0;
            x_pulse <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            x_pulse <= pulse_nxt;
        end
    end

    // A bounce back to the accepted level drops to the stable state with the counter cleared
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    state_nxt = RISE;
                    cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt = '0;
                end
            end
            RISE: begin
                if (!s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    pulse_nxt = (EDGE_MODE != 1);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nxt = FALL;
                    cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt = '0;
                end
            end
            FALL: begin
                if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    pulse_nxt = (EDGE_MODE != 0);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level follows the state register, so it changes on the same edge as the pulse
    assign x_level = (state == HIGH) || (state == FALL);
    assign busy    = (state == RISE) || (state == FALL);

endmodule
